// File: rtl/spi_slave_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx_if
// Description : Bundles the SPI pins and the receive-stream handshake of the
//               spi_slave_rx block.
//               - slave  modport : the receiver (consumes pins and rx_ready,
//                                  produces the byte stream and status).
//               - master modport : the SPI master plus the byte consumer.
//               Ports carried:
//                 spi_cs, spi_sck, spi_sdo : serial pins (async to clk_i)
//                 rx_data[7:0], rx_valid   : FWFT head of receive FIFO
//                 rx_ready                 : consumer accept
//                 fifo_level               : FIFO occupancy
//                 rx_overflow, frame_err   : one-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_rx_if #(
   parameter int FIFO_DEPTH = 4
);
   logic                          spi_cs;
   logic                          spi_sck;
   logic                          spi_sdo;
   logic [7:0]                    rx_data;
   logic                          rx_valid;
   logic                          rx_ready;
   logic [$clog2(FIFO_DEPTH):0]   fifo_level;
   logic                          rx_overflow;
   logic                          frame_err;

   modport slave (
      input  spi_cs, spi_sck, spi_sdo, rx_ready,
      output rx_data, rx_valid, fifo_level, rx_overflow, frame_err
   );

   modport master (
      output spi_cs, spi_sck, spi_sdo, rx_ready,
      input  rx_data, rx_valid, fifo_level, rx_overflow, frame_err
   );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : Oversampling SPI receiver. Synchronises cs/sck/sdo into clk_i,
//               samples sdo on sck falling edges, assembles MSB-first bytes
//               and queues them in a first-word-fall-through FIFO.
//               Ports:
//                 clk_i : system clock (only clock)
//                 rst   : synchronous, active-high reset
//                 bus   : spi_slave_rx_if.slave
//                         - spi_cs/spi_sck/spi_sdo in (asynchronous pins)
//                         - rx_data/rx_valid out, rx_ready in
//                         - fifo_level out, rx_overflow/frame_err pulses out
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk_i,
   input  logic           rst,
   spi_slave_rx_if.slave  bus
);

   localparam int             AW           = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    c_FULL_LEVEL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_WAIT_IDLE = 2'd0,
      S_IDLE      = 2'd1,
      S_RECV      = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // Pin synchronisers and edge detection
   // ------------------------------------------------------------------------
   logic       r_cs_s1,  r_cs_s2,  r_cs_d;
   logic       r_sck_s1, r_sck_s2, r_sck_d;
   logic       r_sdo_s1, r_sdo_s2;
   // Fills with ones after reset; once bit 1 is set the synchroniser outputs
   // reflect the real pins rather than their cleared reset value.
   logic [1:0] r_settle;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_cs_s1  <= 1'b0;
         r_cs_s2  <= 1'b0;
         r_cs_d   <= 1'b0;
         r_sck_s1 <= 1'b0;
         r_sck_s2 <= 1'b0;
         r_sck_d  <= 1'b0;
         r_sdo_s1 <= 1'b0;
         r_sdo_s2 <= 1'b0;
         r_settle <= 2'b00;
      end else begin
         r_cs_s1  <= bus.spi_cs;
         r_cs_s2  <= r_cs_s1;
         r_cs_d   <= r_cs_s2;
         r_sck_s1 <= bus.spi_sck;
         r_sck_s2 <= r_sck_s1;
         r_sck_d  <= r_sck_s2;
         r_sdo_s1 <= bus.spi_sdo;
         r_sdo_s2 <= r_sdo_s1;
         r_settle <= {r_settle[0], 1'b1};
      end
   end

   logic w_sck_fall;
   logic w_cs_rise;
   logic w_cs_fall;

   assign w_sck_fall = r_sck_d  & ~r_sck_s2;
   assign w_cs_rise  = ~r_cs_d  &  r_cs_s2;
   assign w_cs_fall  =  r_cs_d  & ~r_cs_s2;

   // ------------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------------
   state_t     r_state;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_byte_done;
   logic       r_frame_det;
   logic       r_frame_err;

   logic       w_edge;
   logic [2:0] w_cnt_next;
   logic [7:0] w_shift_next;

   // The sck edge is applied before a coincident cs_fall closes the frame, so
   // the post-edge count decides whether the frame ended on a byte boundary.
   assign w_edge       = (r_state == S_RECV) & w_sck_fall;
   assign w_cnt_next   = w_edge ? (r_bit_cnt + 3'd1) : r_bit_cnt;
   assign w_shift_next = w_edge ? {r_shift[6:0], r_sdo_s2} : r_shift;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_state     <= S_WAIT_IDLE;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 8'h00;
         r_byte_done <= 1'b0;
         r_frame_det <= 1'b0;
      end else begin
         r_byte_done <= 1'b0;
         r_frame_det <= 1'b0;
         case (r_state)
            S_WAIT_IDLE: begin
               if (r_settle[1] && !r_cs_s2) begin
                  r_state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (w_cs_rise) begin
                  r_state   <= S_RECV;
                  r_bit_cnt <= 3'd0;
                  r_shift   <= 8'h00;
               end
            end
            S_RECV: begin
               r_bit_cnt   <= w_cnt_next;
               r_shift     <= w_shift_next;
               // 3-bit counter wraps 7 -> 0 exactly when the 8th bit lands.
               r_byte_done <= w_edge && (r_bit_cnt == 3'd7);
               if (w_cs_fall) begin
                  r_state     <= S_IDLE;
                  r_frame_det <= (w_cnt_next != 3'd0);
               end
            end
            default: begin
               r_state <= S_WAIT_IDLE;
            end
         endcase
      end
   end

   // Extra stage aligns frame_err with the byte path (pin to output: 3 clocks).
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= r_frame_det;
      end
   end

   // ------------------------------------------------------------------------
   // Receive FIFO (first-word-fall-through)
   // ------------------------------------------------------------------------
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_empty;
   logic w_write;

   assign w_push  = r_byte_done;
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_FULL_LEVEL);
   assign w_pop   = bus.rx_ready & ~w_empty;
   // When full, a same-cycle pop frees the head slot, which is also the slot
   // the write pointer addresses, so the write can proceed.
   assign w_write = w_push & (~w_full | w_pop);

   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
      end else begin
         r_overflow <= w_push & w_full & ~w_pop;
         if (w_write) begin
            r_mem[r_wr_ptr] <= r_shift;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_write && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_write && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   assign bus.rx_valid    = ~w_empty;
   assign bus.rx_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
   assign bus.fifo_level  = r_count;
   assign bus.rx_overflow = r_overflow;
   assign bus.frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx
// Description : Directed self-checking bench for spi_slave_rx. Drives SPI
//               frames with 5-cycle sck phases and checks the popped byte
//               stream, status pulses and FIFO level.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

   localparam int DEPTH = 4;
   localparam int PH    = 5;

   logic clk_i = 1'b0;
   logic rst   = 1'b1;

   always #5 clk_i = ~clk_i;

   spi_slave_rx_if #(.FIFO_DEPTH(DEPTH)) bus ();

   spi_slave_rx #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i (clk_i),
      .rst   (rst),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Monitor state, sampled on the falling edge
   int         cyc     = 0;
   int         n_ferr  = 0;
   int         n_ovf   = 0;
   int         max_lvl = 0;
   logic [7:0] popq[$];
   int         popc[$];

   always @(negedge clk_i) begin
      cyc = cyc + 1;
      if (!rst) begin
         if (bus.frame_err)   n_ferr = n_ferr + 1;
         if (bus.rx_overflow) n_ovf  = n_ovf + 1;
         if (bus.rx_valid && bus.rx_ready) begin
            popq.push_back(bus.rx_data);
            popc.push_back(cyc);
         end
         if (int'(bus.fifo_level) > max_lvl) max_lvl = int'(bus.fifo_level);
      end
   end

   task automatic clr_mon();
      n_ferr  = 0;
      n_ovf   = 0;
      max_lvl = 0;
      popq.delete();
      popc.delete();
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_bit(input logic b);
      bus.spi_sdo = b;
      bus.spi_sck = 1'b1;
      ticks(PH);
      bus.spi_sck = 1'b0;
      ticks(PH);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic frame_open();
      bus.spi_cs = 1'b1;
      ticks(PH);
   endtask

   task automatic frame_close();
      bus.spi_cs = 1'b0;
      ticks(8);
   endtask

   task automatic send_frame(input logic [7:0] b);
      frame_open();
      send_byte(b);
      frame_close();
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.spi_cs  = 1'b0;
      bus.spi_sck = 1'b0;
      bus.spi_sdo = 1'b0;
      bus.rx_ready = 1'b0;
      ticks(3);
      n_tests++;
      if (bus.rx_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got %b want 0", bus.rx_valid);
      end
      n_tests++;
      if (bus.rx_data !== 8'h00) begin
         n_fail++; $display("FAIL reset_data got %h want 00", bus.rx_data);
      end
      n_tests++;
      if (bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL reset_level got %0d want 0", bus.fifo_level);
      end
      n_tests++;
      if (bus.rx_overflow !== 1'b0 || bus.frame_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses got ovf=%b ferr=%b want 0/0", bus.rx_overflow, bus.frame_err);
      end
      rst = 1'b0;
      ticks(6);
   endtask

   task automatic test_nominal();
      logic [7:0] exp [4];
      exp = '{8'h01, 8'h02, 8'h03, 8'h04};
      clr_mon();
      bus.rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_frame(exp[i]);
      n_tests++;
      if (popq.size() != 4) begin
         n_fail++; $display("FAIL nominal_count got %0d want 4", popq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (popq[i] !== exp[i]) begin
               n_fail++; $display("FAIL nominal_byte%0d got %h want %h", i, popq[i], exp[i]);
            end
         end
      end
      n_tests++;
      if (n_ferr != 0 || n_ovf != 0) begin
         n_fail++; $display("FAIL nominal_status got ferr=%0d ovf=%0d want 0/0", n_ferr, n_ovf);
      end
      n_tests++;
      if (max_lvl > 1) begin
         n_fail++; $display("FAIL nominal_maxlevel got %0d want <=1", max_lvl);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp [4];
      int         k;
      exp = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
      clr_mon();
      bus.rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_frame(exp[i]);
      n_tests++;
      if (bus.fifo_level !== 3'd4 || n_ovf != 0) begin
         n_fail++; $display("FAIL ovf_fill got level=%0d ovf=%0d want 4/0", bus.fifo_level, n_ovf);
      end
      send_frame(8'h3C);
      n_tests++;
      if (n_ovf != 1) begin
         n_fail++; $display("FAIL ovf_pulses got %0d want 1", n_ovf);
      end
      n_tests++;
      if (bus.fifo_level !== 3'd4) begin
         n_fail++; $display("FAIL ovf_level got %0d want 4", bus.fifo_level);
      end
      bus.rx_ready = 1'b1;
      k = 0;
      while (bus.rx_valid && k < 20) begin
         tick();
         k++;
      end
      n_tests++;
      if (bus.rx_valid !== 1'b0) begin
         n_fail++; $display("FAIL ovf_drain got valid=%b want 0", bus.rx_valid);
      end
      n_tests++;
      if (popq.size() != 4) begin
         n_fail++; $display("FAIL ovf_count got %0d want 4", popq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (popq[i] !== exp[i]) begin
               n_fail++; $display("FAIL ovf_byte%0d got %h want %h", i, popq[i], exp[i]);
            end
         end
         n_tests++;
         if (popc[3] - popc[0] != 3) begin
            n_fail++; $display("FAIL ovf_back_to_back got span %0d want 3", popc[3] - popc[0]);
         end
      end
   endtask

   task automatic test_partial();
      clr_mon();
      bus.rx_ready = 1'b1;
      frame_open();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      frame_close();
      n_tests++;
      if (n_ferr != 1) begin
         n_fail++; $display("FAIL partial_ferr got %0d want 1", n_ferr);
      end
      n_tests++;
      if (popq.size() != 0 || bus.fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL partial_nowrite got pops=%0d level=%0d want 0/0", popq.size(), bus.fifo_level);
      end
      send_frame(8'h81);
      n_tests++;
      if (popq.size() != 1 || popq[0] !== 8'h81) begin
         n_fail++; $display("FAIL partial_next got n=%0d b=%h want 1/81", popq.size(), (popq.size() > 0) ? popq[0] : 8'hxx);
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b;
      clr_mon();
      bus.rx_ready = 1'b1;
      b = 8'hB6;
      frame_open();
      for (int i = 7; i >= 4; i--) send_bit(b[i]);
      rst = 1'b1;
      ticks(3);
      rst = 1'b0;
      for (int i = 3; i >= 0; i--) send_bit(b[i]);
      frame_close();
      n_tests++;
      if (popq.size() != 0 || bus.rx_valid !== 1'b0 || n_ferr != 0) begin
         n_fail++; $display("FAIL rstmid_quiet got pops=%0d valid=%b ferr=%0d want 0/0/0", popq.size(), bus.rx_valid, n_ferr);
      end
      send_frame(8'hC3);
      n_tests++;
      if (popq.size() != 1 || popq[0] !== 8'hC3) begin
         n_fail++; $display("FAIL rstmid_next got n=%0d b=%h want 1/c3", popq.size(), (popq.size() > 0) ? popq[0] : 8'hxx);
      end
   endtask

   task automatic test_multibyte();
      clr_mon();
      bus.rx_ready = 1'b1;
      frame_open();
      send_byte(8'hC3);
      send_byte(8'h7E);
      frame_close();
      n_tests++;
      if (popq.size() != 2 || popq[0] !== 8'hC3 || popq[1] !== 8'h7E) begin
         n_fail++; $display("FAIL multi_bytes got n=%0d want 2 bytes c3,7e", popq.size());
      end
      n_tests++;
      if (n_ferr != 0) begin
         n_fail++; $display("FAIL multi_ferr got %0d want 0", n_ferr);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] exp [5];
      int         k;
      exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
      clr_mon();
      bus.rx_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_frame(exp[i]);
      n_tests++;
      if (bus.fifo_level !== 3'd4) begin
         n_fail++; $display("FAIL fullpop_fill got %0d want 4", bus.fifo_level);
      end
      frame_open();
      for (int i = 7; i >= 1; i--) send_bit(exp[4][i]);
      bus.spi_sdo = exp[4][0];
      bus.spi_sck = 1'b1;
      ticks(PH);
      // Falling sck sampled at e0; FIFO write lands at e3.
      bus.spi_sck = 1'b0;
      ticks(3);
      bus.rx_ready = 1'b1;
      tick();
      bus.rx_ready = 1'b0;
      n_tests++;
      if (bus.fifo_level !== 3'd4) begin
         n_fail++; $display("FAIL fullpop_level got %0d want 4", bus.fifo_level);
      end
      ticks(PH);
      frame_close();
      n_tests++;
      if (n_ovf != 0) begin
         n_fail++; $display("FAIL fullpop_ovf got %0d want 0", n_ovf);
      end
      bus.rx_ready = 1'b1;
      k = 0;
      while (bus.rx_valid && k < 20) begin
         tick();
         k++;
      end
      n_tests++;
      if (popq.size() != 5) begin
         n_fail++; $display("FAIL fullpop_count got %0d want 5", popq.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (popq[i] !== exp[i]) begin
               n_fail++; $display("FAIL fullpop_byte%0d got %h want %h", i, popq[i], exp[i]);
            end
         end
      end
   endtask

   initial begin
      bus.spi_cs   = 1'b0;
      bus.spi_sck  = 1'b0;
      bus.spi_sdo  = 1'b0;
      bus.rx_ready = 1'b0;
      test_reset();
      test_nominal();
      test_overflow();
      test_partial();
      test_reset_midframe();
      test_multibyte();
      test_full_pop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
